// File: rtl/layer_if.sv
// Bus between layer_ctrl, its upstream source, the neurons of the layer and the downstream consumer.
// master is the controller side; slave is the environment (source, neurons, sink).
interface layer_if #(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            neuron_in;
    logic                             neuron_in_valid;
    logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out;
    logic [NUM_NEURON-1:0]            neuron_outvalid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             busy;
    logic                             layer_done;
    logic [1:0]                       err;

    modport master (
        input  in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
        output in_ready, neuron_in, neuron_in_valid, out_data, out_valid,
        output busy, layer_done, err
    );

    modport slave (
        output in_data, in_valid, neuron_out, neuron_outvalid, out_ready,
        input  in_ready, neuron_in, neuron_in_valid, out_data, out_valid,
        input  busy, layer_done, err
    );
endinterface

// File: rtl/layer_ctrl.sv
// Sequencer for one fully-connected layer: broadcasts activations to all neurons, gathers
// their results, then serialises them downstream over a valid/ready handshake.
module layer_ctrl #(
    parameter int NUM_NEURON = 30,
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 4096
) (
    input logic    clk,
    input logic    rst,
    layer_if.master bus
);
    localparam int CNT_W  = $clog2(NUM_WEIGHT + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        in_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_d;
    logic [IDX_W-1:0]        out_idx_q;
    logic [NUM_NEURON-1:0]   done_q;
    logic [NUM_NEURON-1:0]   done_d;
    logic [DATA_WIDTH-1:0]   res_buf_q [NUM_NEURON];
    logic [DATA_WIDTH-1:0]   neuron_in_q;
    logic                    neuron_in_valid_q;
    logic                    layer_done_q;
    logic [1:0]              err_q;
    logic                    in_hs;
    logic                    out_hs;
    logic                    out_last;

    assign in_hs      = bus.in_valid & (state_q == S_FEED);
    assign out_hs     = bus.out_ready & (state_q == S_DRAIN);
    assign out_last   = (out_idx_q == IDX_W'(NUM_NEURON - 1));
    // Bits captured this cycle count toward completion, so DRAIN follows the last capture directly.
    assign done_d     = done_q | bus.neuron_outvalid;
    assign wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            in_cnt_q          <= '0;
            wait_cnt_q        <= '0;
            out_idx_q         <= '0;
            done_q            <= '0;
            neuron_in_q       <= '0;
            neuron_in_valid_q <= 1'b0;
            layer_done_q      <= 1'b0;
            err_q             <= '0;
            for (int i = 0; i < NUM_NEURON; i++) begin
                res_buf_q[i] <= '0;
            end
        end else begin
            neuron_in_valid_q <= 1'b0;
            layer_done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FEED;
                end
                S_FEED: begin
                    if (|bus.neuron_outvalid) begin
                        err_q[1] <= 1'b1;
                    end
                    if (in_hs) begin
                        neuron_in_q       <= bus.in_data;
                        neuron_in_valid_q <= 1'b1;
                        in_cnt_q          <= in_cnt_q + CNT_W'(1);
                        if (in_cnt_q == CNT_W'(NUM_WEIGHT - 1)) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    for (int i = 0; i < NUM_NEURON; i++) begin
                        if (bus.neuron_outvalid[i]) begin
                            res_buf_q[i] <= bus.neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    done_q     <= done_d;
                    wait_cnt_q <= wait_cnt_d;
                    // A neuron set completing on the timeout cycle is treated as a normal finish.
                    if (&done_d) begin
                        state_q <= S_DRAIN;
                    end else if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
                        err_q[0] <= 1'b1;
                        state_q  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (|bus.neuron_outvalid) begin
                        err_q[1] <= 1'b1;
                    end
                    if (out_hs) begin
                        if (out_last) begin
                            in_cnt_q     <= '0;
                            out_idx_q    <= '0;
                            wait_cnt_q   <= '0;
                            done_q       <= '0;
                            layer_done_q <= 1'b1;
                            state_q      <= S_FEED;
                            for (int i = 0; i < NUM_NEURON; i++) begin
                                res_buf_q[i] <= '0;
                            end
                        end else begin
                            out_idx_q <= out_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready        = (state_q == S_FEED);
    assign bus.neuron_in       = neuron_in_q;
    assign bus.neuron_in_valid = neuron_in_valid_q;
    assign bus.out_valid       = (state_q == S_DRAIN);
    assign bus.out_data        = (state_q == S_DRAIN) ? res_buf_q[out_idx_q] : '0;
    assign bus.busy            = ((state_q == S_FEED) && (in_cnt_q != '0)) ||
                                 (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign bus.layer_done      = layer_done_q;
    assign bus.err             = err_q;
endmodule
